// File: rtl/vga_gfx_pkg.sv
// Shared constants for the line-buffered VGA graphics peripheral:
// register map, STATUS / INT_CFG bit positions and pixel packing helper.
package vga_gfx_pkg;

  localparam logic [5:0] ADDR_DATA    = 6'h00;
  localparam logic [5:0] ADDR_PTR     = 6'h04;
  localparam logic [5:0] ADDR_CTRL    = 6'h08;
  localparam logic [5:0] ADDR_STATUS  = 6'h0C;
  localparam logic [5:0] ADDR_INT_CFG = 6'h10;
  localparam logic [5:0] ADDR_PAL     = 6'h20;

  localparam logic [1:0] XFER_NONE = 2'b11;
  localparam logic [1:0] XFER_W32  = 2'b10;

  localparam int ST_IRQ  = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_PEND = 2;
  localparam int ST_BANK = 3;

  localparam int INT_SWAP_IE = 0;
  localparam int INT_LINE_IE = 1;
  localparam int INT_CMP_LSB = 2;

  function automatic int ppw(input int bpp);
    return 32 / bpp;
  endfunction

endpackage

// File: rtl/tqvp_vga_gfx_linebuf_if.sv
// TinyQV peripheral bus bundle: the CPU side is master, the peripheral is slave.
interface tqvp_vga_gfx_linebuf_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/vga_linebuf_bank.sv
// Two NUM_WORDS x 32 line buffers in flops: one write port, a combinational
// scan-out read port and a combinational CPU read-back port.
module vga_linebuf_bank #(
  parameter int NUM_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic                         wr_bank,
  input  logic [$clog2(NUM_WORDS)-1:0] wr_idx,
  input  logic [31:0]                  wr_data,
  input  logic                         front_bank,
  input  logic [$clog2(NUM_WORDS)-1:0] front_idx,
  output logic [31:0]                  front_word,
  input  logic                         cpu_bank,
  input  logic [$clog2(NUM_WORDS)-1:0] cpu_idx,
  output logic [31:0]                  cpu_word
);

  logic [31:0] mem_reg [2][NUM_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      always_ff @(posedge clk) begin
        if (we && (wr_bank == 1'(gi))) begin
          mem_reg[gi][wr_idx] <= wr_data;
        end
      end
    end
  endgenerate

  assign front_word = mem_reg[front_bank][front_idx];
  assign cpu_word   = mem_reg[cpu_bank][cpu_idx];

endmodule

// File: rtl/tqvp_vga_gfx_linebuf.sv
// Double-buffered VGA line graphics peripheral: CPU fills the back line while
// the front line is scanned out through a palette with wrap-around scroll.
module tqvp_vga_gfx_linebuf
  import vga_gfx_pkg::*;
#(
  parameter int BPP       = 2,
  parameter int NUM_WORDS = 8,
  parameter int PIX_SHIFT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   ui_in,
  tqvp_vga_gfx_linebuf_if.slave        bus,
  input  logic [10:0]                  vga_x,
  input  logic [9:0]                   vga_y,
  input  logic                         vga_blank,
  input  logic                         vga_hsync,
  input  logic                         vga_vsync,
  output logic [7:0]                   uo_out,
  output logic                         user_interrupt
);

  localparam int AW      = $clog2(NUM_WORDS);
  localparam int PPW     = ppw(BPP);
  localparam int PPW_LOG = $clog2(PPW);
  localparam int PW      = AW + PPW_LOG;
  localparam int NPAL    = 1 << BPP;

  logic          bank_reg, bank_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic          pend_reg, pend_next;
  logic          ovf_reg, ovf_next;
  logic [7:0]    scroll_reg, scroll_next;
  logic [11:0]   int_cfg_reg, int_cfg_next;
  logic          irq_reg, irq_next;
  logic [7:0]    uo_out_reg, uo_out_next;
  logic [5:0]    pal_reg [NPAL];

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in};

  // Bus decode
  logic wr_en, rd_en, data_wr, ptr_wr, ctrl_wr, int_wr, status_rd;
  assign wr_en     = (bus.data_write_n != XFER_NONE);
  assign rd_en     = (bus.data_read_n != XFER_NONE);
  assign data_wr   = (bus.data_write_n == XFER_W32) && (bus.address == ADDR_DATA);
  assign ptr_wr    = wr_en && (bus.address == ADDR_PTR);
  assign ctrl_wr   = wr_en && (bus.address == ADDR_CTRL);
  assign int_wr    = wr_en && (bus.address == ADDR_INT_CFG);
  assign status_rd = rd_en && (bus.address == ADDR_STATUS);

  logic swap_evt, line_evt;
  assign swap_evt = pend_reg && (vga_x == 11'd0);
  assign line_evt = int_cfg_reg[INT_LINE_IE] && (vga_x == 11'd0)
                    && (vga_y == int_cfg_reg[11:INT_CMP_LSB]);

  // A write that coincides with a swap goes to slot 0 of the buffer that is becoming back.
  logic          lb_we, lb_wr_bank;
  logic [AW-1:0] lb_wr_idx;
  assign lb_we      = data_wr;
  assign lb_wr_bank = swap_evt ? bank_reg : ~bank_reg;
  assign lb_wr_idx  = swap_evt ? '0 : wptr_reg;

  always_comb begin
    bank_next    = bank_reg;
    wptr_next    = wptr_reg;
    pend_next    = pend_reg;
    ovf_next     = ovf_reg;
    scroll_next  = scroll_reg;
    int_cfg_next = int_cfg_reg;
    irq_next     = irq_reg;

    if (ctrl_wr) begin
      scroll_next = bus.data_in[15:8];
      if (bus.data_in[0]) pend_next = 1'b1;
    end
    if (int_wr) int_cfg_next = bus.data_in[11:0];

    if (swap_evt) begin
      bank_next = ~bank_reg;
      pend_next = 1'b0;
      wptr_next = data_wr ? AW'(1) : '0;
    end else if (data_wr) begin
      wptr_next = wptr_reg + AW'(1);
      if (wptr_reg == AW'(NUM_WORDS - 1)) ovf_next = 1'b1;
    end else if (ptr_wr) begin
      wptr_next = bus.data_in[AW-1:0];
    end

    if (status_rd) begin
      ovf_next = 1'b0;
      irq_next = 1'b0;
    end
    if ((swap_evt && int_cfg_reg[INT_SWAP_IE]) || line_evt) irq_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_reg    <= 1'b0;
      wptr_reg    <= '0;
      pend_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
      scroll_reg  <= '0;
      int_cfg_reg <= '0;
      irq_reg     <= 1'b0;
      uo_out_reg  <= '0;
    end else begin
      bank_reg    <= bank_next;
      wptr_reg    <= wptr_next;
      pend_reg    <= pend_next;
      ovf_reg     <= ovf_next;
      scroll_reg  <= scroll_next;
      int_cfg_reg <= int_cfg_next;
      irq_reg     <= irq_next;
      uo_out_reg  <= uo_out_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPAL; gi++) begin : g_pal
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pal_reg[gi] <= '0;
        end else if (wr_en && (bus.address == ADDR_PAL + 6'(gi))) begin
          pal_reg[gi] <= bus.data_in[5:0];
        end
      end
    end
  endgenerate

  // Pixel address wraps modulo the whole line, so scrolling rotates the line.
  logic [10:0]        pix_sum;
  logic [PW-1:0]      pix_pos;
  logic [31:0]        front_word, cpu_word, pix_word;
  logic [BPP-1:0]     pix_idx;
  logic [5:0]         colour;

  assign pix_sum  = 11'(vga_x[9:PIX_SHIFT]) + 11'(scroll_reg);
  assign pix_pos  = pix_sum[PW-1:0];
  assign pix_word = front_word >> (32'(pix_pos[PPW_LOG-1:0]) * BPP);
  assign pix_idx  = (vga_blank || vga_x[10]) ? '0 : pix_word[BPP-1:0];
  assign colour   = pal_reg[pix_idx];

  assign uo_out_next = {vga_hsync, colour[0], colour[2], colour[4],
                        vga_vsync, colour[1], colour[3], colour[5]};

  vga_linebuf_bank #(
    .NUM_WORDS (NUM_WORDS)
  ) u_bank (
    .clk        (clk),
    .we         (lb_we),
    .wr_bank    (lb_wr_bank),
    .wr_idx     (lb_wr_idx),
    .wr_data    (bus.data_in),
    .front_bank (bank_reg),
    .front_idx  (pix_pos[PW-1:PPW_LOG]),
    .front_word (front_word),
    .cpu_bank   (~bank_reg),
    .cpu_idx    (wptr_reg),
    .cpu_word   (cpu_word)
  );

  always_comb begin
    bus.data_out = '0;
    if (bus.address[5:BPP] == ADDR_PAL[5:BPP]) begin
      bus.data_out = {26'd0, pal_reg[bus.address[BPP-1:0]]};
    end else begin
      case (bus.address)
        ADDR_DATA:    bus.data_out = cpu_word;
        ADDR_PTR:     bus.data_out = 32'(wptr_reg);
        ADDR_CTRL:    bus.data_out = {16'd0, scroll_reg, 7'd0, pend_reg};
        ADDR_STATUS:  bus.data_out = {28'd0, bank_reg, pend_reg, ovf_reg, irq_reg};
        ADDR_INT_CFG: bus.data_out = {20'd0, int_cfg_reg};
        default:      bus.data_out = '0;
      endcase
    end
  end

  assign bus.data_ready  = 1'b1;
  assign uo_out          = uo_out_reg;
  assign user_interrupt  = irq_reg;

endmodule
